// File: rtl/sqrt_feeder.sv
// Input stage for the Sqrt2 core: operand FIFO, one-per-cycle issue, result-valid delay line.
// Build option: define SQRT_FEEDER_ZERO_IDLE_EN to drive sqrt_in to zero on idle cycles.
module sqrt_feeder #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SQRT_LAT = 2,
    parameter int unsigned W        = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [W-1:0]             s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     en,
    input  logic                     flush,
    output logic [W-1:0]             sqrt_in,
    output logic                     sqrt_in_valid,
    output logic                     res_valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned ADDR = $clog2(DEPTH);
    localparam int unsigned CW   = ADDR + 1;

    logic [W-1:0]    mem_q [DEPTH];
    logic [W-1:0]    mem_d [DEPTH];
    logic [ADDR-1:0] wptr_q, wptr_d;
    logic [ADDR-1:0] rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    sqrt_in_q, sqrt_in_d;
    logic            sqrt_in_valid_q, sqrt_in_valid_d;
    logic            push, pop;

    // Full is judged from count alone; a same-cycle pop never frees a slot early.
    assign s_ready = !reset && (count_q != CW'(DEPTH));
    assign push    = s_valid && s_ready;
    assign pop     = en && (count_q != '0);

    always_comb begin
        mem_d           = mem_q;
        wptr_d          = wptr_q;
        rptr_d          = rptr_q;
        count_d         = count_q;
        sqrt_in_valid_d = 1'b0;
`ifdef SQRT_FEEDER_ZERO_IDLE_EN
        sqrt_in_d       = '0;
`else
        sqrt_in_d       = sqrt_in_q;
`endif
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = s_data;
                wptr_d        = wptr_q + ADDR'(1);
            end
            if (pop) begin
                sqrt_in_d       = mem_q[rptr_q];
                sqrt_in_valid_d = 1'b1;
                rptr_d          = rptr_q + ADDR'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            sqrt_in_q       <= '0;
            sqrt_in_valid_q <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            sqrt_in_q       <= sqrt_in_d;
            sqrt_in_valid_q <= sqrt_in_valid_d;
        end
    end

    assign sqrt_in       = sqrt_in_q;
    assign sqrt_in_valid = sqrt_in_valid_q;
    assign level         = count_q;

    // Flush deliberately leaves this line alone so already-issued results still report.
    if (SQRT_LAT == 0) begin : g_no_dly
        assign res_valid = sqrt_in_valid_q;
    end else begin : g_dly
        logic [SQRT_LAT-1:0] dly_q, dly_d;

        always_comb begin
            dly_d    = dly_q;
            dly_d[0] = sqrt_in_valid_q;
            for (int unsigned i = 1; i < SQRT_LAT; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                dly_q <= '0;
            end else begin
                dly_q <= dly_d;
            end
        end

        assign res_valid = dly_q[SQRT_LAT-1];
    end

endmodule

// File: tb/tb_sqrt_feeder.sv
// Self-checking bench for sqrt_feeder: vector table, directed corner sequences, random traffic
// checked against a queue-based reference model.
module tb_sqrt_feeder;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned LAT   = 2;
    localparam int unsigned W     = 15;

    logic          clk = 1'b0;
    logic          reset, flush, s_valid, s_ready, en;
    logic [W-1:0]  s_data, sqrt_in;
    logic          sqrt_in_valid, res_valid;
    logic [3:0]    level;

    sqrt_feeder #(.DEPTH(DEPTH), .SQRT_LAT(LAT), .W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .en            (en),
        .flush         (flush),
        .sqrt_in       (sqrt_in),
        .sqrt_in_valid (sqrt_in_valid),
        .res_valid     (res_valid),
        .level         (level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue FIFO plus a history of issue-valid bits.
    int          fifo[$];
    logic [W-1:0] m_sin;
    bit          m_vld;
    bit          vh[16];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic cycle(input bit rst, input bit fl, input bit sv, input logic [W-1:0] d,
                         input bit e);
        bit exp_ready, pop, push;
        reset   = rst;
        flush   = fl;
        s_valid = sv;
        s_data  = d;
        en      = e;
        #1;
        exp_ready = !rst && (fifo.size() != DEPTH);
        check("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
        if (rst) begin
            fifo.delete();
            m_sin = '0;
            m_vld = 1'b0;
            for (int k = 0; k < 16; k++) vh[k] = 1'b0;
        end else begin
            for (int k = 15; k > 0; k--) vh[k] = vh[k-1];
            pop  = !fl && e && (fifo.size() != 0);
            push = !fl && sv && exp_ready;
            if (fl) fifo.delete();
            if (pop) begin
                m_sin = W'(fifo.pop_front());
                m_vld = 1'b1;
            end else begin
                m_vld = 1'b0;
`ifdef SQRT_FEEDER_ZERO_IDLE_EN
                m_sin = '0;
`endif
            end
            if (push) fifo.push_back(int'(d));
            vh[0] = m_vld;
        end
        @(posedge clk);
        #1;
        check("sqrt_in_valid", {31'd0, sqrt_in_valid}, {31'd0, m_vld});
        check("sqrt_in", {17'd0, sqrt_in}, {17'd0, m_sin});
        check("res_valid", {31'd0, res_valid}, {31'd0, vh[LAT]});
        check("level", {28'd0, level}, fifo.size());
    endtask

    task automatic idle(input int n, input bit e);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, e);
    endtask

    typedef struct {
        bit           rst;
        bit           sv;
        logic [W-1:0] d;
        bit           e;
        bit           x_ready;
        bit           x_vld;
        bit           chk_sin;
        logic [W-1:0] x_sin;
        bit           x_res;
        logic [3:0]   x_level;
    } vec_t;

    vec_t vt[6];

    initial begin
        int cnt, maxl;

        // Reset, single push of 0x0100, then watch issue and result timing.
        vt[0] = '{1, 0, 15'h0000, 1, 0, 0, 1, 15'h0000, 0, 4'd0};
        vt[1] = '{0, 1, 15'h0100, 1, 1, 0, 1, 15'h0000, 0, 4'd1};
        vt[2] = '{0, 0, 15'h0000, 1, 1, 1, 1, 15'h0100, 0, 4'd0};
        vt[3] = '{0, 0, 15'h0000, 1, 1, 0, 0, 15'h0000, 0, 4'd0};
        vt[4] = '{0, 0, 15'h0000, 1, 1, 0, 0, 15'h0000, 1, 4'd0};
        vt[5] = '{0, 0, 15'h0000, 1, 1, 0, 0, 15'h0000, 0, 4'd0};

        for (int i = 0; i < 6; i++) begin
            reset = vt[i].rst; flush = 1'b0; s_valid = vt[i].sv; s_data = vt[i].d; en = vt[i].e;
            #1;
            check("tbl_ready", {31'd0, s_ready}, {31'd0, vt[i].x_ready});
            cycle(vt[i].rst, 1'b0, vt[i].sv, vt[i].d, vt[i].e);
            check("tbl_vld", {31'd0, sqrt_in_valid}, {31'd0, vt[i].x_vld});
            if (vt[i].chk_sin) check("tbl_sin", {17'd0, sqrt_in}, {17'd0, vt[i].x_sin});
            check("tbl_res", {31'd0, res_valid}, {31'd0, vt[i].x_res});
            check("tbl_level", {28'd0, level}, {28'd0, vt[i].x_level});
        end

        // Overflow with issue stalled, then drain and retry the rejected operands.
        for (int i = 1; i <= 10; i++) cycle(1'b0, 1'b0, 1'b1, W'(i), 1'b0);
        check("full_level", {28'd0, level}, 32'd8);
        check("full_ready", {31'd0, s_ready}, 32'd0);
        idle(2, 1'b0);
        check("hold_level", {28'd0, level}, 32'd8);
        idle(8, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 15'h0009, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 15'h000A, 1'b1);
        idle(5, 1'b1);

        // Streaming at full rate.
        cnt = 0; maxl = 0;
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b0, 1'b1, W'(i), 1'b1);
            if (sqrt_in_valid) cnt++;
            if (int'(level) > maxl) maxl = int'(level);
        end
        check("stream_issues", cnt, 32'd31);
        check("stream_maxlvl", maxl, 32'd1);
        idle(5, 1'b1);

        // Throttled issue; idle sqrt_in checked by the model in both builds.
        cycle(1'b0, 1'b0, 1'b1, 15'h7FFF, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 15'h0000, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 15'h1234, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, '0, (i % 2) == 0);
        idle(4, 1'b1);

        // Flush with level 5 and two results in flight.
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, W'(16'h0200 + i), 1'b0);
        idle(2, 1'b1);
        check("pre_flush_lvl", {28'd0, level}, 32'd5);
        cnt = 0;
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        if (res_valid) cnt++;
        check("flush_level", {28'd0, level}, 32'd0);
        check("flush_vld", {31'd0, sqrt_in_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
            if (res_valid) cnt++;
        end
        check("flush_res_cnt", cnt, 32'd2);

        // Reset with level 3 and results in flight.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, W'(16'h0300 + i), 1'b0);
        idle(2, 1'b1);
        check("pre_rst_lvl", {28'd0, level}, 32'd3);
        cycle(1'b1, 1'b0, 1'b1, 15'h0555, 1'b1);
        check("rst_res", {31'd0, res_valid}, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_sin", {17'd0, sqrt_in}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
            if (res_valid) cnt++;
        end
        check("rst_stale_res", cnt, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(99) == 0, $urandom_range(49) == 0, $urandom_range(1) == 1,
                  W'($urandom), $urandom_range(9) < 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
